// File: rtl/matrix_result_serializer_if.sv
// -----------------------------------------------------------------------------
// matrix_result_serializer_if
// Purpose : valid/ready stream carrying one 3x3 matrix result entry per beat,
//           tagged with its source entry index and an end-of-matrix flag.
// Signals : out_data  - entry value (RESENTRY_SIZE bits)
//           out_index - source entry number 0..8 of out_data
//           out_valid - data/index/last are valid
//           out_ready - consumer accepts the beat when high with out_valid
//           out_last  - high on the ninth beat of a matrix
// Modports: master (serializer side), slave (consumer side)
// -----------------------------------------------------------------------------
interface matrix_result_serializer_if #(
    parameter int RESENTRY_SIZE = 5
);
    logic [RESENTRY_SIZE-1:0] out_data;
    logic [3:0]               out_index;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;

    modport master (
        output out_data,
        output out_index,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_index,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/matrix_result_serializer.sv
// -----------------------------------------------------------------------------
// matrix_result_serializer
// Purpose : captures the nine parallel entries of a 3x3 result matrix on a
//           strobe and streams them out one entry per valid/ready transfer,
//           in row-major or column-major order.
// Ports   : clk       - system clock, rising edge active
//           reset_n   - asynchronous active-low reset
//           capture   - one-cycle strobe: latch c0_in..c8_in, start streaming
//           c0_in..c8_in - parallel result entries, row-major
//           out_if    - master side of the output stream interface
//           busy      - high while a matrix is being streamed
//           overrun   - one-cycle pulse when a capture is dropped
// -----------------------------------------------------------------------------
module matrix_result_serializer #(
    parameter int RESENTRY_SIZE = 5,
    parameter bit COL_MAJOR     = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         capture,
    input  logic [RESENTRY_SIZE-1:0]     c0_in,
    input  logic [RESENTRY_SIZE-1:0]     c1_in,
    input  logic [RESENTRY_SIZE-1:0]     c2_in,
    input  logic [RESENTRY_SIZE-1:0]     c3_in,
    input  logic [RESENTRY_SIZE-1:0]     c4_in,
    input  logic [RESENTRY_SIZE-1:0]     c5_in,
    input  logic [RESENTRY_SIZE-1:0]     c6_in,
    input  logic [RESENTRY_SIZE-1:0]     c7_in,
    input  logic [RESENTRY_SIZE-1:0]     c8_in,
    matrix_result_serializer_if.master   out_if,
    output logic                         busy,
    output logic                         overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [RESENTRY_SIZE-1:0] buf_q [9];
    logic [RESENTRY_SIZE-1:0] buf_d [9];
    logic [RESENTRY_SIZE-1:0] cIn   [9];
    logic [3:0]               cnt_q, cnt_d;
    logic                     overrun_q, overrun_d;
    logic [3:0]               outIndex;
    logic                     finalBeat;

    assign cIn[0] = c0_in;
    assign cIn[1] = c1_in;
    assign cIn[2] = c2_in;
    assign cIn[3] = c3_in;
    assign cIn[4] = c4_in;
    assign cIn[5] = c5_in;
    assign cIn[6] = c6_in;
    assign cIn[7] = c7_in;
    assign cIn[8] = c8_in;

    // Map the sequence counter onto the buffer slot to emit. Column-major
    // walks down each column: counter 0..8 -> 0,3,6,1,4,7,2,5,8.
    always_comb begin
        outIndex = cnt_q;
        if (COL_MAJOR) begin
            outIndex = 4'((cnt_q % 4'd3) * 4'd3 + cnt_q / 4'd3);
        end
    end

    assign out_if.out_valid = (state_q == SEND);
    assign out_if.out_index = outIndex;
    assign out_if.out_data  = buf_q[outIndex];
    assign out_if.out_last  = (state_q == SEND) && (cnt_q == 4'd8);
    assign busy             = (state_q == SEND);
    assign overrun          = overrun_q;

    // The ninth beat is being accepted this cycle; a capture arriving now is
    // taken as a back-to-back matrix rather than flagged as an overrun.
    assign finalBeat = (state_q == SEND) && out_if.out_ready && (cnt_q == 4'd8);

    // Next-state logic. Captures are only latched in IDLE or on the final
    // transfer; any other capture while streaming is dropped and reported
    // through a registered one-cycle overrun pulse.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        overrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    buf_d   = cIn;
                    cnt_d   = 4'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (finalBeat) begin
                    cnt_d = 4'd0;
                    if (capture) begin
                        buf_d = cIn;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (out_if.out_ready) begin
                        cnt_d = cnt_q + 4'd1;
                    end
                    if (capture) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. Reset discards any partially streamed matrix and
    // clears the buffer so all outputs read zero immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            overrun_q <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
            buf_q     <= buf_d;
        end
    end

endmodule

// File: tb/tb_matrix_result_serializer.sv
// -----------------------------------------------------------------------------
// tb_matrix_result_serializer
// Purpose : drives one row-major and one column-major serializer with the same
//           directed captures; expected beats are queued when a capture is
//           issued and popped by per-instance monitors as beats are accepted.
// -----------------------------------------------------------------------------
module tb_matrix_result_serializer;

    typedef logic [0:8][4:0] mat_t;

    typedef struct {
        logic [4:0] data;
        logic [3:0] idx;
        logic       last;
    } beat_t;

    logic clk;
    logic reset_n;
    logic capture;
    logic ready;
    mat_t cIn;
    logic busy0, busy1, ovr0, ovr1;

    int nChecks = 0;
    int nFails  = 0;

    beat_t expQ [2][$];

    // Hand-written column-major emission order
    logic [3:0] colIdx [9] = '{4'd0, 4'd3, 4'd6, 4'd1, 4'd4, 4'd7, 4'd2, 4'd5, 4'd8};

    matrix_result_serializer_if #(.RESENTRY_SIZE(5)) if0 ();
    matrix_result_serializer_if #(.RESENTRY_SIZE(5)) if1 ();

    assign if0.out_ready = ready;
    assign if1.out_ready = ready;

    matrix_result_serializer #(.RESENTRY_SIZE(5), .COL_MAJOR(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .capture(capture),
        .c0_in(cIn[0]), .c1_in(cIn[1]), .c2_in(cIn[2]),
        .c3_in(cIn[3]), .c4_in(cIn[4]), .c5_in(cIn[5]),
        .c6_in(cIn[6]), .c7_in(cIn[7]), .c8_in(cIn[8]),
        .out_if(if0.master), .busy(busy0), .overrun(ovr0)
    );

    matrix_result_serializer #(.RESENTRY_SIZE(5), .COL_MAJOR(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .capture(capture),
        .c0_in(cIn[0]), .c1_in(cIn[1]), .c2_in(cIn[2]),
        .c3_in(cIn[3]), .c4_in(cIn[4]), .c5_in(cIn[5]),
        .c6_in(cIn[6]), .c7_in(cIn[7]), .c8_in(cIn[8]),
        .out_if(if1.master), .busy(busy1), .overrun(ovr1)
    );

    logic       vld [2];
    logic [4:0] dat [2];
    logic [3:0] idx [2];
    logic       lst [2];

    assign vld[0] = if0.out_valid;
    assign vld[1] = if1.out_valid;
    assign dat[0] = if0.out_data;
    assign dat[1] = if1.out_data;
    assign idx[0] = if0.out_index;
    assign idx[1] = if1.out_index;
    assign lst[0] = if0.out_last;
    assign lst[1] = if1.out_last;

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        nChecks++;
        if (actual !== required) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    // Queue the nine beats each instance is expected to emit for matrix m
    task automatic pushExpected(input mat_t m);
        for (int k = 0; k < 9; k++) begin
            expQ[0].push_back('{data: m[k], idx: 4'(k), last: (k == 8)});
            expQ[1].push_back('{data: m[colIdx[k]], idx: colIdx[k], last: (k == 8)});
        end
    endtask

    // Pulse capture for one cycle starting just after a rising edge, then
    // scramble the inputs so late sampling would be caught.
    task automatic applyStimulus(input mat_t m, input bit accept);
        cIn     = m;
        capture = 1'b1;
        if (accept) pushExpected(m);
        @(posedge clk);
        #1;
        capture = 1'b0;
        for (int k = 0; k < 9; k++) cIn[k] = 5'($urandom);
    endtask

    // Bounded wait until both instances have emitted everything queued
    task automatic waitDrain(input string name, input int budget);
        int i;
        i = 0;
        while (i < budget && !(expQ[0].size() == 0 && expQ[1].size() == 0
                               && !busy0 && !busy1)) begin
            @(posedge clk);
            #1;
            i++;
        end
        checkOutput({name, " drained"}, (i < budget) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, " valid0"}, {31'd0, vld[0]}, 0);
        checkOutput({name, " valid1"}, {31'd0, vld[1]}, 0);
        checkOutput({name, " data0"},  {27'd0, dat[0]}, 0);
        checkOutput({name, " data1"},  {27'd0, dat[1]}, 0);
        checkOutput({name, " index0"}, {28'd0, idx[0]}, 0);
        checkOutput({name, " index1"}, {28'd0, idx[1]}, 0);
        checkOutput({name, " last0"},  {31'd0, lst[0]}, 0);
        checkOutput({name, " last1"},  {31'd0, lst[1]}, 0);
        checkOutput({name, " busy"},   {30'd0, busy1, busy0}, 0);
        checkOutput({name, " overrun"}, {30'd0, ovr1, ovr0}, 0);
    endtask

    // Per-instance monitors: on each falling edge compare any presented beat
    // against the head of that instance's queue, pop it when accepted, and
    // make sure a stalled beat stays put until it is taken.
    for (genvar g = 0; g < 2; g++) begin : mon
        bit         held;
        logic [4:0] hData;
        logic [3:0] hIdx;
        logic       hLast;
        always @(negedge clk) begin
            beat_t e;
            if (!reset_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    checkOutput($sformatf("dut%0d hold valid", g), {31'd0, vld[g]}, 1);
                    checkOutput($sformatf("dut%0d hold data", g),  {27'd0, dat[g]}, {27'd0, hData});
                    checkOutput($sformatf("dut%0d hold index", g), {28'd0, idx[g]}, {28'd0, hIdx});
                    checkOutput($sformatf("dut%0d hold last", g),  {31'd0, lst[g]}, {31'd0, hLast});
                end
                if (vld[g]) begin
                    if (expQ[g].size() == 0) begin
                        nChecks++;
                        nFails++;
                        $display("[TB] FAIL dut%0d unexpected beat: got data %0d index %0d, required no beat",
                                 g, dat[g], idx[g]);
                    end else begin
                        e = expQ[g][0];
                        checkOutput($sformatf("dut%0d beat data", g),  {27'd0, dat[g]}, {27'd0, e.data});
                        checkOutput($sformatf("dut%0d beat index", g), {28'd0, idx[g]}, {28'd0, e.idx});
                        checkOutput($sformatf("dut%0d beat last", g),  {31'd0, lst[g]}, {31'd0, e.last});
                        if (ready) void'(expQ[g].pop_front());
                    end
                    held  = !ready;
                    hData = dat[g];
                    hIdx  = idx[g];
                    hLast = lst[g];
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    // Safety net so the run always ends
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        mat_t mA, mAll31, mB, mJunk;
        bit   pat [4];
        mA     = '{5'd1, 5'd2, 5'd3, 5'd8, 5'd9, 5'd10, 5'd15, 5'd16, 5'd17};
        mAll31 = '{5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31};
        mB     = '{5'd4, 5'd0, 5'd30, 5'd7, 5'd21, 5'd12, 5'd5, 5'd26, 5'd19};
        mJunk  = '{5'd11, 5'd22, 5'd13, 5'd24, 5'd6, 5'd27, 5'd14, 5'd29, 5'd20};
        pat    = '{1'b1, 1'b0, 1'b0, 1'b1};

        reset_n = 1'b0;
        capture = 1'b0;
        ready   = 1'b0;
        cIn     = '0;

        // Reset then idle
        #3;
        checkAllZero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("idle valid", {30'd0, vld[1], vld[0]}, 0);
            checkOutput("idle busy", {30'd0, busy1, busy0}, 0);
        end

        // Basic stream: one beat per cycle, then back to idle
        @(posedge clk);
        #1;
        ready = 1'b1;
        applyStimulus(mA, 1'b1);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            checkOutput($sformatf("basic valid beat %0d", k), {30'd0, vld[1], vld[0]}, 3);
            checkOutput($sformatf("basic busy beat %0d", k), {30'd0, busy1, busy0}, 3);
        end
        @(negedge clk);
        checkOutput("basic valid after", {30'd0, vld[1], vld[0]}, 0);
        checkOutput("basic busy after", {30'd0, busy1, busy0}, 0);
        waitDrain("basic", 20);

        // Backpressure with ready pattern 1,0,0,1 repeating
        @(posedge clk);
        #1;
        applyStimulus(mA, 1'b1);
        for (int i = 0; i < 60; i++) begin
            if (expQ[0].size() == 0 && expQ[1].size() == 0) break;
            ready = pat[i % 4];
            @(posedge clk);
            #1;
        end
        ready = 1'b1;
        waitDrain("backpressure", 20);

        // Overrun during beat 3, then a back-to-back capture on beat 9
        @(posedge clk);
        #1;
        applyStimulus(mA, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        applyStimulus(mJunk, 1'b0);
        checkOutput("overrun pulse", {30'd0, ovr1, ovr0}, 3);
        @(posedge clk);
        #1;
        checkOutput("overrun one cycle", {30'd0, ovr1, ovr0}, 0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        applyStimulus(mAll31, 1'b1);
        checkOutput("b2b no overrun", {30'd0, ovr1, ovr0}, 0);
        checkOutput("b2b no gap", {30'd0, vld[1], vld[0]}, 3);
        waitDrain("b2b", 30);

        // Asynchronous reset in the middle of beat 4
        @(posedge clk);
        #1;
        applyStimulus(mA, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset_n = 1'b0;
        #1;
        checkAllZero("midreset");
        expQ[0].delete();
        expQ[1].delete();
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("post-reset valid", {30'd0, vld[1], vld[0]}, 0);
        end
        @(posedge clk);
        #1;
        applyStimulus(mB, 1'b1);
        waitDrain("post-reset stream", 20);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/matrix_result_serializer.md
Name: matrix_result_serializer

Overview:
Output-side companion to the 3x3 matrix multiplier. It captures the nine parallel result entries c0..c8 on a strobe and streams them out one entry per transfer over a valid/ready interface. Each beat carries its source entry index and an end-of-matrix flag. It sits between the multiplier's c*_out bus and any narrow downstream consumer (UART bridge, memory writer, host readback).

Parameters:
RESENTRY_SIZE, 5, bit width of each result entry and of out_data
COL_MAJOR, 0, emission order: 0 = row-major (c0,c1,...,c8), 1 = column-major (c0,c3,c6,c1,c4,c7,c2,c5,c8)

Ports:
clk  input  1  system clock, rising-edge active
reset_n  input  1  asynchronous, active-low reset
capture  input  1  one-cycle strobe: latch c0_in..c8_in and begin streaming
c0_in..c8_in  input  RESENTRY_SIZE each  parallel result entries, row-major (c0 = row0/col0, c8 = row2/col2)
out_data  output  RESENTRY_SIZE  current entry value
out_index  output  4  source entry number (0..8) of out_data
out_valid  output  1  out_data/out_index/out_last are valid
out_ready  input  1  consumer accepts the beat when high together with out_valid
out_last  output  1  high on the ninth beat of a matrix
busy  output  1  high while a matrix is being streamed
overrun  output  1  one-cycle pulse when a capture is dropped

Behaviour:
- One clock domain, clk. reset_n is asynchronous and active-low: on assertion, all state clears immediately regardless of clk.
- Reset values: out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, overrun=0. Capture buffer cleared to 0; state=IDLE; sequence counter=0.
- Reset asserted mid-stream aborts the matrix. No further beats are emitted and the partial matrix is discarded.
- FSM has two states, IDLE and SEND.
- IDLE, capture=1:
  - Latch all nine inputs into the buffer.
  - Set counter=0 and go to SEND.
  - out_valid rises on the next clk edge (latency 1 cycle from capture to first beat).
- IDLE, capture=0: no change.
- Sequence counter runs 0..8. out_index maps the counter to a source entry:
  - COL_MAJOR=0: out_index = counter.
  - COL_MAJOR=1: out_index = (counter mod 3)*3 + counter/3.
- out_data = buffer[out_index].
- out_last = out_valid && (counter==8).
- Transfer occurs when out_valid && out_ready at a clk edge.
  - counter<8: counter increments.
  - counter==8: return to IDLE and drop out_valid, unless a capture is accepted in the same cycle (see below).
- While out_valid=1 and out_ready=0, out_data, out_index and out_last hold stable. out_valid never drops without a transfer, except on reset.
- Throughput is one beat per cycle when out_ready is held high. A full matrix takes 9 cycles after the first beat appears.
- busy = (state==SEND).
- capture=1 in SEND with no final transfer that cycle:
  - Ignored; buffer and counter are unchanged.
  - overrun pulses high for exactly one cycle, on the following clk edge.
- capture=1 in the same cycle as the final transfer (counter==8, out_ready=1): accepted as a back-to-back matrix.
  - The new entries are latched, counter=0, state stays SEND.
  - out_valid stays high with no bubble; no overrun.
- Input values are sampled only on the accepting capture edge. c*_in may change freely at all other times.
- Entries are passed through unmodified; no truncation, sign handling or arithmetic.

Test Plan:
- Reset then idle: reset_n low, capture=0 -> all outputs 0; after release, out_valid stays 0 and busy=0 for 10 cycles.
- Basic stream, COL_MAJOR=0: c0..c8 = 1,2,3,8,9,10,15,16,17; capture for 1 cycle; out_ready=1.
  - out_valid rises next cycle.
  - Beats are 1,2,3,8,9,10,15,16,17 with out_index 0..8 on consecutive cycles.
  - out_last only on beat 17; then out_valid=0 and busy=0.
- Backpressure: same data; out_ready toggles 1,0,0,1,...
  - Each beat holds value/index stable while ready=0.
  - No beat is lost or duplicated; 9 beats total.
- Column-major, COL_MAJOR=1: same data -> beats 1,8,15,2,9,16,3,10,17 with out_index 0,3,6,1,4,7,2,5,8.
- Overrun and back-to-back, COL_MAJOR=0, out_ready=1:
  - capture at beat 3 -> overrun pulses once; stream continues with the original data.
  - capture coincident with beat 9 (data all 5'd31) -> nine beats of 31 follow with no gap and no overrun.
- Reset mid-stream: assert reset_n low asynchronously between clk edges during beat 4 -> outputs clear immediately.
  - After release with no capture, nothing is emitted.
  - A new capture streams correctly from index 0.
